console_keys: RTL and testbench

CONSOLE_KEYS -- requirements
Module: console_keys

---
 rtl/console_keys_if.sv | 11 +
 rtl/console_keys.sv | 175 +++++++++++++++++
 tb/tb_console_keys.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/console_keys_if.sv
// Console key bundle: raw keys and repeat switch in, debounced level/pulse/busy out.
interface console_keys_if;
  logic [0:11] key_in;
  logic        sw_repeat;
  logic [0:11] key_lvl;
  logic [0:11] key_pls;
  logic        busy;

  modport master (output key_in, sw_repeat, input key_lvl, key_pls, busy);
  modport slave  (input key_in, sw_repeat, output key_lvl, key_pls, busy);
endinterface

// File: rtl/console_keys.sv
// Console key debouncer: captures the lowest pressed key, debounces press/release, one-cycle press pulse.
// Auto-repeat while the repeat switch is on is built only when KEY_REPEAT_EN is defined.
module console_keys #(
  parameter int unsigned DEB_CYCLES = 20,
  parameter int unsigned REP_CYCLES = 2000
) (
  input  logic           clk,
  input  logic           reset,
  console_keys_if.slave  kif
);

  localparam int unsigned NKEYS   = 12;
`ifdef KEY_REPEAT_EN
  localparam int unsigned CNT_MAX = (DEB_CYCLES > REP_CYCLES) ? DEB_CYCLES : REP_CYCLES;
`else
  localparam int unsigned CNT_MAX = DEB_CYCLES;
`endif
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_ACTIVE, S_RELEASE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sel_q, sel_d;
  logic [0:NKEYS-1] ks1_q, ks_q;
  logic [0:NKEYS-1] key_lvl_q, key_lvl_d;
  logic [0:NKEYS-1] key_pls_q, key_pls_d;
  logic            busy_q, busy_d;
  logic            any_c;
  logic            key_hi_c;
  logic [3:0]      first_c;

  function automatic logic [0:NKEYS-1] onehot(input logic [3:0] idx);
    onehot = '0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (4'(i) == idx) onehot[i] = 1'b1;
    end
  endfunction

  // Two-flop synchronizers for the asynchronous key and repeat inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ks1_q <= '0;
      ks_q  <= '0;
    end else begin
      ks1_q <= kif.key_in;
      ks_q  <= ks1_q;
    end
  end

`ifdef KEY_REPEAT_EN
  logic rs1_q, rs_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q <= 1'b0;
      rs_q  <= 1'b0;
    end else begin
      rs1_q <= kif.sw_repeat;
      rs_q  <= rs1_q;
    end
  end
`else
  logic unused_sw_repeat_c;
  assign unused_sw_repeat_c = kif.sw_repeat;
`endif

  // Priority pick: lowest-numbered high key wins
  always_comb begin
    first_c = '0;
    any_c   = |ks_q;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (ks_q[i]) first_c = 4'(i);
    end
    key_hi_c = (sel_q < 4'(NKEYS)) ? ks_q[sel_q] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (any_c) begin
          sel_d   = first_c;
          cnt_d   = '0;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!key_hi_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (!key_hi_c) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
`ifdef KEY_REPEAT_EN
          if (!rs_q || cnt_q == REP_LAST) cnt_d = '0;
          else                            cnt_d = cnt_q + CW'(1);
`else
          cnt_d = '0;
`endif
        end
      end
      S_RELEASE: begin
        // A bounce back high resumes ACTIVE without a new press pulse
        if (key_hi_c) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    logic fire;
    fire = (state_q == S_DEBOUNCE) && (state_d == S_ACTIVE);
`ifdef KEY_REPEAT_EN
    if ((state_q == S_ACTIVE) && key_hi_c && rs_q && (cnt_q == REP_LAST)) fire = 1'b1;
`endif
    key_pls_d = fire ? onehot(sel_q) : '0;
    key_lvl_d = ((state_d == S_ACTIVE) || (state_d == S_RELEASE)) ? onehot(sel_d) : '0;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_lvl_q <= '0;
      key_pls_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      key_lvl_q <= key_lvl_d;
      key_pls_q <= key_pls_d;
      busy_q    <= busy_d;
    end
  end

  assign kif.key_lvl = key_lvl_q;
  assign kif.key_pls = key_pls_q;
  assign kif.busy    = busy_q;

endmodule

// File: tb/tb_console_keys.sv
// Self-checking bench for console_keys: directed scenarios plus random press/release runs
// checked against a run-length model of the debounce rules.
module tb_console_keys;
  localparam int DEB  = 20;
  localparam int REP  = 100;
  localparam int MAXT = 512;
  localparam int TAIL = 2 * DEB + 5;

  logic clk = 1'b0;
  logic reset;
  console_keys_if kif ();

  console_keys #(.DEB_CYCLES(DEB), .REP_CYCLES(REP)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #25 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [0:11] oh(input int k);
    logic [0:11] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk_vec(input string tag, input logic [0:11] got, input logic [0:11] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive on the falling edge; return 1 time unit after the rising edge that samples it
  task automatic step(input logic [0:11] kv, input logic rv, input logic rst);
    @(negedge clk);
    kif.key_in    = kv;
    kif.sw_repeat = rv;
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  // One key, alternating high/low runs, then a long low tail.
  // Model: a high run of >= DEB+1 samples from idle is accepted with pulse/level DEB+2 edges
  // after its first sample; a low run of >= DEB+1 samples while held drops the level
  // DEB+2 edges after its first low sample; shorter runs change nothing.
  task automatic run_trial(input int k, input int h0, input int l0, input int h1,
                           input int l1, input int h2);
    bit w [MAXT];
    bit el[MAXT];
    bit ep[MAXT];
    int len, s, n, on_from;
    bit held, any_hi, busy_seen;
    int runs[6];
    runs = '{h0, l0, h1, l1, h2, TAIL};
    len = 0;
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < runs[r]; j++) begin
        w[len] = (r % 2 == 0);
        len++;
      end
    for (int t = 0; t < MAXT; t++) begin
      el[t] = 1'b0;
      ep[t] = 1'b0;
    end
    held = 0; on_from = 0; any_hi = 0; s = 0;
    while (s < len) begin
      n = 1;
      while (s + n < len && w[s + n] == w[s]) n++;
      if (w[s]) any_hi = 1;
      if (w[s] && !held && n >= DEB + 1) begin
        on_from = s + DEB + 2;
        if (on_from < len) ep[on_from] = 1'b1;
        held = 1;
      end else if (!w[s] && held && n >= DEB + 1) begin
        for (int t = on_from; t < s + DEB + 2 && t < len; t++) el[t] = 1'b1;
        held = 0;
      end
      s += n;
    end
    if (held) for (int t = on_from; t < len; t++) el[t] = 1'b1;

    busy_seen = 0;
    for (int t = 0; t < len; t++) begin
      step(w[t] ? oh(k) : 12'b0, 1'b0, 1'b0);
      busy_seen |= kif.busy;
      chk_vec($sformatf("trial k=%0d t=%0d key_lvl", k, t), kif.key_lvl, el[t] ? oh(k) : 12'b0);
      chk_vec($sformatf("trial k=%0d t=%0d key_pls", k, t), kif.key_pls, ep[t] ? oh(k) : 12'b0);
    end
    chk_bit($sformatf("trial k=%0d busy_end", k), kif.busy, 1'b0);
    chk_bit($sformatf("trial k=%0d busy_seen", k), busy_seen, any_hi);
  endtask

  initial begin
    logic [0:11] kv, el, ep;
    int npls;
    kif.key_in = '0; kif.sw_repeat = 1'b0; reset = 1'b1;

    // Reset state
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
    chk_vec("reset key_lvl", kif.key_lvl, '0);
    chk_vec("reset key_pls", kif.key_pls, '0);
    chk_bit("reset busy", kif.busy, 1'b0);
    for (int i = 0; i < 5; i++) step('0, 1'b0, 1'b0);
    chk_bit("idle busy", kif.busy, 1'b0);

    // Directed single-key runs: long press, glitch, debounce boundaries, release bounce
    run_trial(10, 40, 0, 0, 0, 0);
    run_trial(0, 10, 0, 0, 0, 0);
    run_trial(3, DEB, 0, 0, 0, 0);
    run_trial(4, DEB + 1, 0, 0, 0, 0);
    run_trial(5, 40, 5, 5, 0, 0);
    run_trial(6, 40, DEB, 3, 0, 0);
    run_trial(7, 40, DEB + 1, 30, 0, 0);

    // Random runs
    for (int r = 0; r < 12; r++)
      run_trial(int'($urandom_range(11)), int'($urandom_range(1, 2 * DEB + 2)),
                int'($urandom_range(1, 2 * DEB + 2)), int'($urandom_range(1, 2 * DEB + 2)),
                int'($urandom_range(1, 2 * DEB + 2)), int'($urandom_range(1, 2 * DEB + 2)));

    // Simultaneous 8 and 11: 8 wins, 11 captured once 8 clears
    for (int t = 0; t < 200; t++) begin
      kv = '0;
      if (t < 40)  kv[8]  = 1'b1;
      if (t < 120) kv[11] = 1'b1;
      step(kv, 1'b0, 1'b0);
      el = '0; ep = '0;
      if (t >= DEB + 2 && t < 40 + DEB + 2) el[8] = 1'b1;
      if (t == DEB + 2) ep[8] = 1'b1;
      if (t >= 40 + DEB + 2 + DEB + 1 && t < 120 + DEB + 2) el[11] = 1'b1;
      if (t == 40 + DEB + 2 + DEB + 1) ep[11] = 1'b1;
      chk_vec($sformatf("dual t=%0d key_lvl", t), kif.key_lvl, el);
      chk_vec($sformatf("dual t=%0d key_pls", t), kif.key_pls, ep);
    end

    // Reset mid-ACTIVE with key 2 held, then re-debounce from scratch
    for (int t = 0; t < 170; t++) begin
      step((t < 100) ? oh(2) : 12'b0, 1'b0, t == 40);
      el = '0; ep = '0;
      if (t < 40) begin
        if (t >= DEB + 2) el = oh(2);
        if (t == DEB + 2) ep = oh(2);
      end else if (t > 40) begin
        if (t >= 41 + DEB + 2 && t < 100 + DEB + 2) el = oh(2);
        if (t == 41 + DEB + 2) ep = oh(2);
      end
      chk_vec($sformatf("rst t=%0d key_lvl", t), kif.key_lvl, el);
      chk_vec($sformatf("rst t=%0d key_pls", t), kif.key_pls, ep);
      if (t == 40) chk_bit("rst busy", kif.busy, 1'b0);
    end

    // Key 1 held 450 cycles with repeat switch on
    npls = 0;
    for (int t = 0; t < 550; t++) begin
      step((t < 450) ? oh(1) : 12'b0, 1'b1, 1'b0);
      el = (t >= DEB + 2 && t < 450 + DEB + 2) ? oh(1) : 12'b0;
`ifdef KEY_REPEAT_EN
      ep = (t >= DEB + 2 && (t - DEB - 2) % REP == 0 && t < 452) ? oh(1) : 12'b0;
`else
      ep = (t == DEB + 2) ? oh(1) : 12'b0;
`endif
      if (kif.key_pls != '0) npls++;
      chk_vec($sformatf("rep t=%0d key_lvl", t), kif.key_lvl, el);
      chk_vec($sformatf("rep t=%0d key_pls", t), kif.key_pls, ep);
    end
`ifdef KEY_REPEAT_EN
    chk_bit("rep pulse_count", npls == 5, 1'b1);
`else
    chk_bit("rep pulse_count", npls == 1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
